polyveck_unpack_w1: RTL and testbench
=====================================

# polyveck_unpack_w1

Streaming decoder for the packed high-bits vector w1 (K = 6 polynomials, 256 coefficients each, 4 bits per coefficient, 128 bytes per polynomial, 768 bytes total). It accepts the packed byte stream with a valid/ready handshake and emits one zero-extended 32-bit coefficient per cycle, tagged with polynomial and coefficient indices. It is the inverse of the team's w1 packer and feeds the w1-comparison and rehash paths in verification and test.

## Interface

**Parameters**
- `K`, 6: number of polynomials per frame.
- `BYTES_PER_POLY`, 128: packed bytes per polynomial, 256 coefficients / 2.

**Ports**
- `clk`, input, 1: single clock; all logic is on the rising edge.
- `rst`, input, 1: reset, synchronous and active-high.
- `in_data`, input, 8: packed byte.
- `in_valid`, input, 1: `in_data` is valid.
- `in_last`, input, 1: marks the final byte of a frame. Used only when `POLYVECK_UNPACK_W1_ERR_EN` is defined.
- `in_ready`, output, 1: the block accepts a byte this cycle.
- `out_data`, output, 32: coefficient, `{28'b0, nibble}`.
- `out_valid`, output, 1: `out_data` and its tags are valid.
- `out_ready`, input, 1: the downstream consumer accepts the coefficient.
- `out_poly_idx`, output, 3: polynomial index, 0..K-1.
- `out_coeff_idx`, output, 8: coefficient index, 0..255.
- `out_last`, output, 1: the current coefficient ends the frame.
- `err`, output, 1: one-cycle frame-length error pulse.

## Operation

**Byte layout**
- Byte j of polynomial p unpacks as: coeff 2j = `byte[3:0]`, coeff 2j+1 = `byte[7:4]`.
- The low nibble is always emitted first.

**State machine**
- `EMPTY`: no byte is held.
  - `in_ready` = 1.
  - On `in_valid`: latch the byte, go to `LO`.
- `LO`: the low nibble is presented.
  - `in_ready` = 0.
  - On `out_ready`: go to `HI`.
- `HI`: the high nibble is presented.
  - `in_ready` = `out_ready`.
  - If `out_ready && in_valid`: latch the new byte and go to `LO` (back-to-back, no bubble).
  - Else if `out_ready`: go to `EMPTY`.

**Handshake rules**
- `out_valid` = 1 exactly in `LO` and `HI`.
- While `out_valid && !out_ready`, `out_data`, `out_poly_idx`, `out_coeff_idx` and `out_last` are held stable.
- `in_ready` never depends on `in_valid`.

**Counters**
- `byte_cnt` runs 0..K*BYTES_PER_POLY-1 (0..767). It advances when the high nibble is consumed.
- `out_poly_idx` = `byte_cnt / BYTES_PER_POLY`.
- `out_coeff_idx` = `2*(byte_cnt % BYTES_PER_POLY) + (state==HI)`.
- `out_last` = 1 in `HI` when `byte_cnt` = 767.
- `byte_cnt` wraps to 0 after byte 767's high nibble is consumed; the next frame starts immediately.

**Reset**
- Reset mid-frame discards the held byte and the count.
- Next cycle: state = `EMPTY`, `byte_cnt` = 0.

**Reset values**
- `out_valid`, `out_data`, `out_poly_idx`, `out_coeff_idx`, `out_last`, `err` = 0.
- `in_ready` = 1.

## Timing

- Byte accepted in cycle N: low nibble valid in N+1. High nibble valid in the cycle after the low nibble is consumed.
- Sustained throughput with `out_ready` = 1: one coefficient per cycle, one byte per 2 cycles.
- Full frame: 1536 coefficients in 1536 cycles after the first output.
- Outputs are driven from registers; `in_ready` is a function of state and `out_ready` only.

## Configuration

`POLYVECK_UNPACK_W1_ERR_EN`

**Defined**
- `in_last` is checked against `byte_cnt`.
- Early `in_last` (byte index < 767):
  - The byte is still unpacked.
  - Its high nibble is emitted with `out_last` = 1.
  - `byte_cnt` then resets to 0.
  - `err` pulses for 1 cycle, in the cycle after acceptance.
- Missing `in_last` on byte 767:
  - `err` pulses for 1 cycle, in the cycle after acceptance.
  - The counter wraps normally.

**Not defined**
- `in_last` is ignored and `err` is tied to 0.
- Frames are delimited by count only.

## Test plan

- **Reset:** assert `rst` for 2 cycles → `in_ready` = 1, all other outputs 0. A byte offered during reset is not accepted.
- **Full frame, continuous:** 768 bytes, byte 0 = 0xA5, byte 128 = 0x21, byte 767 = 0xF0, `out_ready` = 1.
  - Coefficient (0,0) = 5, then (0,1) = 10.
  - (1,0) = 1, then (1,1) = 2.
  - (5,254) = 0, then (5,255) = 15 with `out_last` = 1.
  - Exactly 1536 `out_valid` cycles, back-to-back.
- **Backpressure:** hold byte 0x3C in `LO`, `out_ready` = 0 for 3 cycles → `out_data` stays 0xC, `in_ready` = 0. Release → 0xC, then 0x3.
- **Mid-frame reset:** reset after 300 bytes, then send a new frame whose byte 0 = 0x76 → first output is `out_poly_idx` 0, `out_coeff_idx` 0, data 6.
- **Two frames back-to-back:** the second frame's first coefficient follows (5,255) with no gap and is tagged (0,0).
- **`POLYVECK_UNPACK_W1_ERR_EN`:**
  - `in_last` on byte 10 → `err` pulse, `out_last` on (0,21), and the next byte maps to (0,0).
  - No `in_last` on byte 767 → `err` pulse.

Source files
------------

// File: rtl/polyveck_unpack_w1.sv
// polyveck_unpack_w1: streams packed 4-bit w1 bytes in, coefficients out.
// Ports: in_* byte stream (valid/ready, in_last), out_* coefficient
// stream (valid/ready, poly/coeff tags, out_last), err length pulse.
// Optional macro POLYVECK_UNPACK_W1_ERR_EN enables in_last checking.
module polyveck_unpack_w1 #(
  parameter int K              = 6,
  parameter int BYTES_PER_POLY = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [2:0]  out_poly_idx,
  output logic [7:0]  out_coeff_idx,
  output logic        out_last,
  output logic        err
);

  localparam int TOTAL = K * BYTES_PER_POLY;
  localparam int CW    = $clog2(TOTAL);
  localparam logic [CW-1:0] LAST = CW'(TOTAL - 1);
  localparam logic [CW-1:0] BPP  = CW'(BYTES_PER_POLY);

  typedef enum logic [1:0] {
    S_EMPTY,
    S_LO,
    S_HI
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [7:0]      r_byte;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  logic            w_hi_done;
  logic            w_acc;
  logic            w_vld;
  logic            w_early;
  logic            w_frame_end;
  logic [3:0]      w_nib;

  assign w_hi_done   = (r_state == S_HI) && out_ready;
  assign in_ready    = (r_state == S_EMPTY) || w_hi_done;
  assign w_acc       = in_ready && in_valid;
  assign w_frame_end = (r_cnt == LAST) || w_early;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_EMPTY: if (in_valid) w_state_nxt = S_LO;
      S_LO:    if (out_ready) w_state_nxt = S_HI;
      S_HI: begin
        if (out_ready)
          w_state_nxt = in_valid ? S_LO : S_EMPTY;
      end
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  // Count of the byte that follows the one currently held; when a byte
  // is accepted this is exactly that byte's index within the frame.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_hi_done)
      w_cnt_nxt = w_frame_end ? '0 : r_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_EMPTY;
      r_byte  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_acc)
        r_byte <= in_data;
    end
  end

`ifdef POLYVECK_UNPACK_W1_ERR_EN
  logic r_early;
  logic r_err;
  logic w_is_last;

  assign w_is_last = (w_cnt_nxt == LAST);

  // r_early marks a held byte that closed its frame before byte TOTAL-1;
  // it truncates the frame once that byte's high nibble drains.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_early <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_acc && (in_last != w_is_last);
      if (w_acc)
        r_early <= in_last && !w_is_last;
    end
  end

  assign w_early = r_early;
  assign err     = r_err;
`else
  logic w_unused_last;

  assign w_unused_last = in_last;
  assign w_early       = 1'b0;
  assign err           = 1'b0;
`endif

  assign w_vld = (r_state != S_EMPTY);
  assign w_nib = (r_state == S_HI) ? r_byte[7:4] : r_byte[3:0];

  assign out_valid     = w_vld;
  assign out_data      = w_vld ? {28'b0, w_nib} : '0;
  assign out_poly_idx  = w_vld ? 3'(r_cnt / BPP) : '0;
  assign out_coeff_idx = w_vld ?
    {7'(r_cnt % BPP), (r_state == S_HI)} : '0;
  assign out_last      = (r_state == S_HI) && w_frame_end;

endmodule

// File: tb/tb_polyveck_unpack_w1.sv
// tb_polyveck_unpack_w1: directed self-checking bench
// for the w1 coefficient unpacker.
module tb_polyveck_unpack_w1;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_poly_idx;
  logic [7:0]  out_coeff_idx;
  logic        out_last;
  logic        err;

  polyveck_unpack_w1 dut (
    .clk          (clk),
    .rst          (rst),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_last      (in_last),
    .in_ready     (in_ready),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_poly_idx (out_poly_idx),
    .out_coeff_idx(out_coeff_idx),
    .out_last     (out_last),
    .err          (err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0] b [768];
  logic [3:0] cap_data  [3072];
  logic [2:0] cap_poly  [3072];
  logic [7:0] cap_coeff [3072];
  logic       cap_last  [3072];
  int first_cyc, last_cyc, n_out, mdl_errs, err_cnt;
  int last_at = -1;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    in_last = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run(input int nbytes, input bit mdl);
    int pi, cyc;
    logic [7:0] bv;
    logic [3:0] en;
    pi = 0; cyc = 0; n_out = 0;
    mdl_errs = 0; err_cnt = 0; first_cyc = -1; last_cyc = -1;
    while (n_out < 2 * nbytes && cyc < 8000) begin
      @(negedge clk);
      in_valid  = (pi < nbytes);
      in_data   = b[pi % 768];
      in_last   = (pi == last_at);
      out_ready = 1'b1;
      #4;
      if (err) err_cnt++;
      if (out_valid && out_ready) begin
        cap_data[n_out]  = out_data[3:0];
        cap_poly[n_out]  = out_poly_idx;
        cap_coeff[n_out] = out_coeff_idx;
        cap_last[n_out]  = out_last;
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        if (mdl) begin
          bv = b[(n_out / 2) % 768];
          en = (n_out % 2) ? bv[7:4] : bv[3:0];
          if (out_data !== {28'b0, en} ||
              out_poly_idx != 3'(((n_out / 2) % 768) / 128) ||
              out_coeff_idx != 8'(((n_out / 2) % 128) * 2 + n_out % 2) ||
              out_last != ((n_out % 1536) == 1535))
            mdl_errs++;
        end
        n_out++;
      end
      if (in_valid && in_ready) pi++;
      cyc++;
    end
    chk("run_done", n_out, 2 * nbytes);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 768; i++) b[i] = 8'((i * 7 + 3) & 8'hFF);
    b[0]   = 8'hA5;
    b[128] = 8'h21;
    b[766] = 8'h30;
    b[767] = 8'hF0;

    // reset, with a byte offered that must be ignored
    rst = 1'b1; in_valid = 1'b1; in_data = 8'h55;
    in_last = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", out_valid, 0);
    chk("post_rst_data", out_data, 0);
    chk("post_rst_poly", out_poly_idx, 0);
    chk("post_rst_coeff", out_coeff_idx, 0);
    chk("post_rst_last", out_last, 0);
    chk("post_rst_err", err, 0);
    chk("post_rst_rdy", in_ready, 1);

    // two full frames back-to-back
    run(1536, 1'b1);
    chk("model", mdl_errs, 0);
    chk("n_valid", n_out, 3072);
    chk("no_gap", last_cyc - first_cyc, 3071);
    chk("c0_0", cap_data[0], 5);
    chk("c0_1", cap_data[1], 10);
    chk("c1_0", cap_data[256], 1);
    chk("c1_0_tag", {cap_poly[256], cap_coeff[256]}, {3'd1, 8'd0});
    chk("c1_1", cap_data[257], 2);
    chk("c5_254", cap_data[1534], 0);
    chk("c5_255", cap_data[1535], 15);
    chk("c5_255_tag", {cap_poly[1535], cap_coeff[1535]},
        {3'd5, 8'd255});
    chk("c5_255_last", cap_last[1535], 1);
    chk("c5_254_last", cap_last[1534], 0);
    chk("f2_first_tag", {cap_poly[1536], cap_coeff[1536]}, 0);
    chk("f2_first", cap_data[1536], 5);
    chk("f2_last", cap_last[3071], 1);
`ifndef POLYVECK_UNPACK_W1_ERR_EN
    chk("err_off", err_cnt, 0);
`endif

    // backpressure on the low nibble
    do_reset();
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'h3C; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_valid", out_valid, 1);
      chk("bp_data", out_data, 32'hC);
      chk("bp_rdy", in_ready, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_rel_lo", out_data, 32'hC);
    @(negedge clk);
    chk("bp_hi", out_data, 32'h3);
    chk("bp_hi_idx", out_coeff_idx, 1);
    chk("bp_hi_rdy", in_ready, 1);
    @(negedge clk);
    chk("bp_empty", out_valid, 0);

    // reset in the middle of a frame
    do_reset();
    run(300, 1'b1);
    chk("mid_model", mdl_errs, 0);
    do_reset();
    b[0] = 8'h76;
    run(1, 1'b0);
    chk("mid_tag", {cap_poly[0], cap_coeff[0]}, 0);
    chk("mid_data", cap_data[0], 6);
    b[0] = 8'hA5;

`ifdef POLYVECK_UNPACK_W1_ERR_EN
    do_reset();
    last_at = 10;
    run(11, 1'b0);
    chk("early_err", err_cnt, 1);
    chk("early_last", cap_last[21], 1);
    chk("early_tag", {cap_poly[21], cap_coeff[21]}, {3'd0, 8'd21});
    last_at = -1;
    run(1, 1'b0);
    chk("early_next", {cap_poly[0], cap_coeff[0]}, 0);
    chk("early_next_err", err_cnt, 0);
    do_reset();
    run(768, 1'b0);
    chk("miss_err", err_cnt, 1);
    chk("miss_last", cap_last[1535], 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
